// File: rtl/disp_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan controller.
// Anode patterns are active-low; AN_OFF darkens every digit.
package disp_pkg;

    localparam int DIGITS = 4;
    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

    function automatic logic [DIGITS-1:0] onehot_low(input logic [1:0] idx);
        logic [DIGITS-1:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_tick.sv
// Digit-slot timebase: free-running prescaler plus the 2-bit digit index.
// gap marks the last cycle of each slot, when the index advances.
module scan_tick #(
    parameter int DIV_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       gap
);

    logic [DIV_BITS-1:0] div_cnt;

    assign gap = &div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (gap)
                idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit common-anode display: shadows the hex value and
// masks, then drives nibble/blank/point for the downstream decoder plus anodes.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  blank_in,
    input  logic        lzb,
    output logic [3:0]  HEX,
    output logic        LE,
    output logic        POINT,
    output logic [3:0]  AN
);

    logic [15:0]       data_q;
    logic [DIGITS-1:0] point_q;
    logic [DIGITS-1:0] blank_q;
    logic              lzb_q;

    logic [1:0]        idx;
    logic              gap;

    logic [DIGITS-1:0] nz;
    logic [DIGITS-1:0] upper_zero;
    logic [DIGITS-1:0] lz_blank;
    logic [3:0]        cur_nib;

    scan_tick #(.DIV_BITS(DIV_BITS)) u_tick (
        .clk (clk),
        .rst (rst),
        .idx (idx),
        .gap (gap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            point_q <= '0;
            blank_q <= '0;
            lzb_q   <= 1'b0;
        end else if (load) begin
            data_q  <= data_in;
            point_q <= point_in;
            blank_q <= blank_in;
            lzb_q   <= lzb;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign nz[i] = |data_q[4*i +: 4];
    end

    // upper_zero[i]: this nibble and all more-significant ones are zero
    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = ~nz[DIGITS-1];
        for (int i = DIGITS - 2; i >= 0; i--)
            upper_zero[i] = ~nz[i] & upper_zero[i+1];
        lz_blank = lzb_q ? {upper_zero[DIGITS-1:1], 1'b0} : '0;
    end

    assign cur_nib = data_q[{idx, 2'b00} +: 4];

    // Forced blank also kills POINT since the decoder's DP path ignores LE
    always_ff @(posedge clk) begin
        if (rst) begin
            AN    <= AN_OFF;
            HEX   <= '0;
            LE    <= 1'b1;
            POINT <= 1'b0;
        end else if (gap) begin
            AN    <= AN_OFF;
            HEX   <= cur_nib;
            LE    <= 1'b1;
            POINT <= 1'b0;
        end else begin
            AN    <= onehot_low(idx);
            HEX   <= cur_nib;
            LE    <= blank_q[idx] | lz_blank[idx];
            POINT <= point_q[idx] & ~blank_q[idx];
        end
    end

endmodule
